prog_counter: RTL

- Parametrised successor to the lab's basic counter.
- Programmable up/down counter with:
  - synchronous load
  - programmable modulo limit
  - three end-of-count modes: wrap, saturate, one-shot
  - built-in clock-enable prescaler
- Drives timing/event logic in the lab top levels (display refresh, tone/delay generation), replacing ad-hoc free-running counters.

---
 rtl/prog_counter_pkg.sv | 22 ++
 rtl/prog_counter_clk_prescaler.sv | 36 +++
 rtl/prog_counter.sv | 119 +++++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// rtl/prog_counter_pkg.sv - shared types and helpers for the programmable counter
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The reserved encoding behaves exactly like WRAP.
  function automatic logic is_wrap(input mode_e m);
    return (m == MODE_WRAP) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/prog_counter_clk_prescaler.sv
// rtl/prog_counter_clk_prescaler.sv - divide-by-(div+1) clock-enable generator
module clk_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt_q;
  logic [PRE_W-1:0] pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (run && en) begin
      pcnt_d = (pcnt_q == div) ? '0 : pcnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign tick = run & en & (pcnt_q == div);

endmodule

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - programmable up/down counter with modulo limit and end-of-count modes
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] div,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic tick, clr, step, at_bound, accept_start;

  assign clr          = start | ld | stop;
  assign step         = tick & ~clr;
  assign at_bound     = dir_q ? (count_q == limit) : (count_q == '0);
  assign accept_start = start & ~stop & (state_q != S_RUN);

  clk_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (state_q == S_RUN),
    .en   (en),
    .div  (div),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_WRAP;
      dir_q   <= 1'b1;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_start) state_d = S_RUN;
      S_RUN: begin
        if (stop) state_d = S_IDLE;
        else if (step && at_bound && mode_q == MODE_ONESHOT) state_d = S_DONE;
      end
      S_DONE: begin
        if (stop) state_d = S_IDLE;
        else if (accept_start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Compare before any add/subtract so no intermediate value can overflow.
  always_comb begin
    mode_d  = accept_start ? mode_e'(mode) : mode_q;
    dir_d   = accept_start ? dir : dir_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (ld) begin
      count_d = (v > limit) ? limit : v;
    end else if (step) begin
      if (dir_q) begin
        if (count_q < limit) begin
          count_d = count_q + WIDTH'(1);
          tc_d    = (count_q == limit - WIDTH'(1));
        end else if (count_q > limit) begin
          count_d = limit;
          tc_d    = 1'b1;
        end else if (is_wrap(mode_q)) begin
          count_d = '0;
          tc_d    = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
          tc_d    = (count_q == WIDTH'(1));
        end else if (is_wrap(mode_q)) begin
          count_d = limit;
          tc_d    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    count = count_q;
    tc    = tc_q;
  end

endmodule
